// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// The optional read-modify-write store path is enabled with DMEM_RMW_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge for partial stores: each of the four lanes takes the new
// byte when its enable bit is set, otherwise keeps the old byte.
// Only instantiated when DMEM_RMW_EN is defined.
module be_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [3:0]        i_be,
  output logic [DATA_W-1:0] o_merged
);

  localparam int unsigned LANE_W = DATA_W / 4;

  // Lane-wise select between old and new word
  always_comb begin
    o_merged = i_old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        o_merged[i*LANE_W +: LANE_W] = i_new[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port word RAM between CPU instruction fetch and data port.
// Avalon-style handshakes; data has priority, bounded by MAX_DATA_BURST
// consecutive data grants while fetch is pending.
// Define DMEM_RMW_EN to turn partial-byteenable stores into read-modify-write.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic              instr_read,
  output logic [DATA_W-1:0] instr_readdata,
  output logic              instr_waitrequest,
  input  logic [ADDR_W-1:0] data_address,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [DATA_W-1:0] data_writedata,
  input  logic [3:0]        data_byteenable,
  output logic [DATA_W-1:0] data_readdata,
  output logic              data_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_burst_cnt;

  logic              w_data_req;
  logic              w_data_win;
  logic              w_rmw_go;
  logic              w_be_none;
  logic [DATA_W-1:0] w_rmw_word;
  logic              w_done;

  assign w_data_req = data_read | data_write;
  assign w_data_win = w_data_req && !(instr_read && (r_burst_cnt == CNT_MAX));

`ifdef DMEM_RMW_EN
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_merged;
  logic [DATA_W-1:0] w_merged;

  be_merge #(.DATA_W(DATA_W)) u_be_merge (
    .i_old    (mem_readdata),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  assign w_be_none  = r_write && (r_be == 4'b0000);
  assign w_rmw_go   = r_write && (r_be != BE_FULL) && !w_be_none;
  assign w_rmw_word = r_merged;

  // Latch store lane mask at grant and the merged word during the RMW read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_be     <= '0;
      r_merged <= '0;
    end else begin
      if (r_state == IDLE && w_data_win) r_be <= data_byteenable;
      if (r_state == ACCESS && w_rmw_go) r_merged <= w_merged;
    end
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^data_byteenable;
  assign w_be_none   = 1'b0;
  assign w_rmw_go    = 1'b0;
  assign w_rmw_word  = r_wdata;
`endif

  // Arbitration, request latching, burst counting and state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_INSTR;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_data_win) begin
            r_owner <= OWN_DATA;
            r_addr  <= data_address;
            r_write <= data_write;
            r_wdata <= data_writedata;
            r_state <= ACCESS;
            if (instr_read && (r_burst_cnt != CNT_MAX)) begin
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
          end else if (instr_read) begin
            r_owner     <= OWN_INSTR;
            r_addr      <= instr_address;
            r_write     <= 1'b0;
            r_burst_cnt <= '0;
            r_state     <= ACCESS;
          end
        end
        ACCESS:  r_state <= w_rmw_go ? RMW_WR : IDLE;
        RMW_WR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes and handshake outputs; reset forces the idle values in the
  // same cycle so a store caught in ACCESS never reaches the RAM's clock edge
  always_comb begin
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = '0;
    instr_waitrequest = 1'b1;
    data_waitrequest  = 1'b1;
    instr_readdata    = '0;
    data_readdata     = '0;
    w_done            = 1'b0;
    if (!reset) begin
      case (r_state)
        ACCESS: begin
          mem_address = r_addr;
          if (!r_write) begin
            mem_read = 1'b1;
            w_done   = 1'b1;
          end else if (w_rmw_go) begin
            mem_read = 1'b1;
          end else if (w_be_none) begin
            w_done = 1'b1;
          end else begin
            mem_write     = 1'b1;
            mem_writedata = r_wdata;
            w_done        = 1'b1;
          end
        end
        RMW_WR: begin
          mem_address   = r_addr;
          mem_write     = 1'b1;
          mem_writedata = w_rmw_word;
          w_done        = 1'b1;
        end
        default: ;
      endcase
      if (w_done) begin
        if (r_owner == OWN_DATA) begin
          data_waitrequest = 1'b0;
          if (!r_write) data_readdata = mem_readdata;
        end else begin
          instr_waitrequest = 1'b0;
          instr_readdata    = mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural word RAM
// (combinational read, posedge write) and a backdoor preload port.
module tb_data_mem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] ram [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_count = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_read(instr_read),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  assign mem_readdata = ram[mem_address[7:2]];

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_write) ram[mem_address[7:2]] <= mem_writedata;
    if (mem_write) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [5:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    step();
    bd_we = 1'b0;
  endtask

  initial begin
    int wr_before;
    reset = 1'b1;
    instr_address = '0; data_address = '0; data_writedata = '0;
    data_byteenable = 4'hF; data_write = 1'b0;
    instr_read = 1'b1; data_read = 1'b1;

    // 1: reset held with both requests active
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_iwait", {31'd0, instr_waitrequest}, 32'd1);
      check("rst_dwait", {31'd0, data_waitrequest}, 32'd1);
      check("rst_mrd",   {31'd0, mem_read}, 32'd0);
      check("rst_mwr",   {31'd0, mem_write}, 32'd0);
      step();
    end
    check("rst_idata", instr_readdata, 32'd0);
    reset = 1'b0; instr_read = 1'b0; data_read = 1'b0;

    bd_write(6'd4, 32'hDEADBEEF);
    bd_write(6'd5, 32'h55667788);
    bd_write(6'd8, 32'h11223344);
    bd_write(6'd9, 32'hCAFEF00D);

    // 2: fetch only
    instr_address = 32'h10; instr_read = 1'b1;
    check("f_idle_wait", {31'd0, instr_waitrequest}, 32'd1);
    check("f_idle_mrd",  {31'd0, mem_read}, 32'd0);
    step();
    check("f_wait",  {31'd0, instr_waitrequest}, 32'd0);
    check("f_data",  instr_readdata, 32'hDEADBEEF);
    check("f_maddr", mem_address, 32'h10);
    check("f_mrd",   {31'd0, mem_read}, 32'd1);
    check("f_dwait", {31'd0, data_waitrequest}, 32'd1);
    instr_read = 1'b0;
    step();
    check("f_after_wait", {31'd0, instr_waitrequest}, 32'd1);
    check("f_after_data", instr_readdata, 32'd0);

    // 3: simultaneous requests, data first
    instr_read = 1'b1; data_address = 32'h14; data_read = 1'b1;
    step();
    check("both_dwait", {31'd0, data_waitrequest}, 32'd0);
    check("both_ddata", data_readdata, 32'h55667788);
    check("both_iwait", {31'd0, instr_waitrequest}, 32'd1);
    data_read = 1'b0;
    step();
    check("both_idle_iwait", {31'd0, instr_waitrequest}, 32'd1);
    step();
    check("both_iwait2", {31'd0, instr_waitrequest}, 32'd0);
    check("both_idata",  instr_readdata, 32'hDEADBEEF);
    instr_read = 1'b0;
    step();

    // 4: burst limit, expected grant order D D D D I (01 = data, 10 = instr)
    instr_read = 1'b1; data_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("burst_g%0d", k), {30'd0, ~instr_waitrequest, ~data_waitrequest},
            (k < 4) ? 32'd1 : 32'd2);
      if (k == 4) begin
        instr_read = 1'b0; data_read = 1'b0;
      end
      step();
    end
    check("burst_cnt_clr", 32'(dut.r_burst_cnt), 32'd0);

    // 5: partial store to word 8 (0x20)
    data_address = 32'h20; data_writedata = 32'hAABBCCDD;
    data_byteenable = 4'b0101; data_write = 1'b1;
    step();
`ifdef DMEM_RMW_EN
    check("rmw_rd_wait", {31'd0, data_waitrequest}, 32'd1);
    check("rmw_rd_mrd",  {31'd0, mem_read}, 32'd1);
    check("rmw_rd_mwr",  {31'd0, mem_write}, 32'd0);
    step();
    check("rmw_wr_wait", {31'd0, data_waitrequest}, 32'd0);
    check("rmw_wr_mwr",  {31'd0, mem_write}, 32'd1);
    check("rmw_wr_data", mem_writedata, 32'h11BB33DD);
    data_write = 1'b0;
    step();
    check("rmw_ram", ram[8], 32'h11BB33DD);
    // empty lane mask: completes in ACCESS without touching RAM
    data_byteenable = 4'b0000; data_writedata = 32'h99999999; data_write = 1'b1;
    step();
    check("be0_wait", {31'd0, data_waitrequest}, 32'd0);
    check("be0_mwr",  {31'd0, mem_write}, 32'd0);
    data_write = 1'b0;
    step();
    check("be0_ram", ram[8], 32'h11BB33DD);
`else
    check("full_wait", {31'd0, data_waitrequest}, 32'd0);
    check("full_mwr",  {31'd0, mem_write}, 32'd1);
    check("full_data", mem_writedata, 32'hAABBCCDD);
    data_write = 1'b0;
    step();
    check("full_ram", ram[8], 32'hAABBCCDD);
`endif

    // read back through the data port
    data_read = 1'b1;
    step();
    check("rb_wait", {31'd0, data_waitrequest}, 32'd0);
`ifdef DMEM_RMW_EN
    check("rb_data", data_readdata, 32'h11BB33DD);
`else
    check("rb_data", data_readdata, 32'hAABBCCDD);
`endif
    data_read = 1'b0;
    step();

    // 6: reset during ACCESS of a full store
    data_address = 32'h24; data_writedata = 32'h12345678;
    data_byteenable = 4'hF; data_write = 1'b1;
    step();
    wr_before = wr_count;
    reset = 1'b1;
    #1;
    check("rstacc_mwr", {31'd0, mem_write}, 32'd0);
    step();
    check("rstacc_state", 32'(dut.r_state), 32'(IDLE));
    check("rstacc_dwait", {31'd0, data_waitrequest}, 32'd1);
    check("rstacc_iwait", {31'd0, instr_waitrequest}, 32'd1);
    check("rstacc_ram",   ram[9], 32'hCAFEF00D);
    check("rstacc_wrcnt", 32'(wr_count), 32'(wr_before));
    reset = 1'b0; data_write = 1'b0;
    step();
    check("post_mwr", {31'd0, mem_write}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
